// File: rtl/alu_mdu_responder_pkg.sv
// Shared types and helpers for the iterative multiply/divide responder.
package alu_mdu_responder_pkg;

    localparam int unsigned MDU_ITER = 16;

    typedef enum logic [2:0] {
        OpMul  = 3'd0,
        OpDiv  = 3'd1,
        OpRem  = 3'd2,
        OpMuls = 3'd3,
        OpDivs = 3'd4,
        OpRems = 3'd5
    } mdu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
        logic d;
    } mdu_status_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StFixup,
        StDone
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return op inside {OpDiv, OpRem, OpDivs, OpRems};
    endfunction

    function automatic logic op_is_rem(input mdu_op_e op);
        return op inside {OpRem, OpRems};
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return op inside {OpMuls, OpDivs, OpRems};
    endfunction

endpackage

// File: rtl/alu_mdu_responder_if.sv
// Request/response handshake bundle between the execute stage and the multiply/divide responder.
interface alu_mdu_responder_if
    import alu_mdu_responder_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_ITER
);

    logic             req_valid;
    logic             req_ready;
    mdu_op_e          req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_out;
    logic [WIDTH-1:0] rsp_hi;
    mdu_status_t      rsp_stat;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_hi, rsp_stat
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_hi, rsp_stat
    );

endinterface

// File: rtl/alu_mdu_responder_mdu_step.sv
// One iteration of the multiply/divide datapath: right shift-add for multiply,
// left shift and restoring subtract for divide. Purely combinational.
module alu_mdu_responder_mdu_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        shifted = {acc_i, lo_i[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_i};
        if (is_div_i) begin
            // A borrow out of the top bit means the trial subtract must be undone
            if (diff[WIDTH]) begin
                acc_o = shifted[WIDTH-1:0];
                lo_o  = {lo_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = diff[WIDTH-1:0];
                lo_o  = {lo_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = sum[WIDTH:1];
            lo_o  = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_mdu_responder.sv
// Iterative multiply / divide / remainder responder beside the single-cycle ALU.
// Define MDU_SIGNED_EN to add two's-complement ops with a sign-fixup state.
module alu_mdu_responder
    import alu_mdu_responder_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_ITER
) (
    input  logic               clk,
    input  logic               rst,
    alu_mdu_responder_if.slave mdu_io
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    mdu_state_e       state_q, state_d;
    mdu_op_e          op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    mdu_status_t      stat_q, stat_d;

    logic             req_div, req_sgn, a_neg, b_neg, div_zero;
    logic [WIDTH-1:0] a_mag, b_mag, zero_out, zero_hi;

    assign req_div = op_is_div(mdu_io.req_op);
`ifdef MDU_SIGNED_EN
    assign req_sgn = op_is_signed(mdu_io.req_op);
`else
    assign req_sgn = 1'b0;
`endif
    assign a_neg    = req_sgn & mdu_io.req_a[WIDTH-1];
    assign b_neg    = req_sgn & mdu_io.req_b[WIDTH-1];
    assign a_mag    = a_neg ? -mdu_io.req_a : mdu_io.req_a;
    assign b_mag    = b_neg ? -mdu_io.req_b : mdu_io.req_b;
    assign div_zero = req_div & (mdu_io.req_b == '0);
    assign zero_out = op_is_rem(mdu_io.req_op) ? mdu_io.req_a : '1;
    assign zero_hi  = op_is_rem(mdu_io.req_op) ? '1 : mdu_io.req_a;

    logic op_div, op_rem, op_sgn, last_iter, need_fix;

    assign op_div = op_is_div(op_q);
    assign op_rem = op_is_rem(op_q);
`ifdef MDU_SIGNED_EN
    assign op_sgn = op_is_signed(op_q);
`else
    assign op_sgn = 1'b0;
`endif
    assign last_iter = (cnt_q == CntLast);
    assign need_fix  = neg_lo_q | neg_hi_q;

    logic [WIDTH-1:0] step_acc, step_lo;

    alu_mdu_responder_mdu_step #(
        .WIDTH (WIDTH)
    ) u_mdu_step (
        .is_div_i (op_div),
        .acc_i    (acc_q),
        .lo_i     (lo_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc),
        .lo_o     (step_lo)
    );

    // Final result: raw halves come from the last step, or from the registers in FIXUP
    logic [WIDTH-1:0] raw_hi, raw_lo, fin_hi, fin_lo, res_out, res_hi;
    mdu_status_t      res_stat;

    always_comb begin
        raw_hi = (state_q == StBusy) ? step_acc : acc_q;
        raw_lo = (state_q == StBusy) ? step_lo : lo_q;
        fin_hi = raw_hi;
        fin_lo = raw_lo;
`ifdef MDU_SIGNED_EN
        if (op_div) begin
            if (neg_lo_q) fin_lo = -raw_lo;
            if (neg_hi_q) fin_hi = -raw_hi;
        end else if (neg_lo_q) begin
            {fin_hi, fin_lo} = -{raw_hi, raw_lo};
        end
`endif
        res_out    = op_rem ? fin_hi : fin_lo;
        res_hi     = op_rem ? fin_lo : fin_hi;
        res_stat.z = (res_out == '0);
        res_stat.n = res_out[WIDTH-1];
        if (op_div) begin
            res_stat.v = ovf_q;
        end else if (op_sgn) begin
            res_stat.v = (res_hi != {WIDTH{res_out[WIDTH-1]}});
        end else begin
            res_stat.v = (res_hi != '0);
        end
        res_stat.d = 1'b0;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (mdu_io.req_valid) state_d = div_zero ? StDone : StBusy;
            StBusy: if (last_iter) state_d = need_fix ? StFixup : StDone;
`ifdef MDU_SIGNED_EN
            StFixup: state_d = StDone;
`endif
            StDone: if (mdu_io.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mdu_io.req_ready = (state_q == StIdle);
        mdu_io.rsp_valid = (state_q == StDone);
        mdu_io.rsp_out   = out_q;
        mdu_io.rsp_hi    = hi_q;
        mdu_io.rsp_stat  = stat_q;
    end

    // Datapath next state
    always_comb begin
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        ovf_d    = ovf_q;
        out_d    = out_q;
        hi_d     = hi_q;
        stat_d   = stat_q;
        case (state_q)
            StIdle: begin
                if (mdu_io.req_valid) begin
                    op_d     = mdu_io.req_op;
                    opnd_d   = req_div ? b_mag : a_mag;
                    acc_d    = '0;
                    lo_d     = req_div ? a_mag : b_mag;
                    cnt_d    = '0;
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = req_div & a_neg;
                    // Most-negative / -1 is the only quotient that cannot be represented
                    ovf_d    = req_sgn & req_div & (mdu_io.req_a == {1'b1, {(WIDTH-1){1'b0}}})
                               & (mdu_io.req_b == '1);
                    if (div_zero) begin
                        out_d  = zero_out;
                        hi_d   = zero_hi;
                        stat_d = '{z: (zero_out == '0), n: zero_out[WIDTH-1], v: 1'b0, d: 1'b1};
                    end
                end
            end
            StBusy: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = last_iter ? '0 : cnt_q + 1'b1;
                if (last_iter && !need_fix) begin
                    out_d  = res_out;
                    hi_d   = res_hi;
                    stat_d = res_stat;
                end
            end
`ifdef MDU_SIGNED_EN
            StFixup: begin
                out_d  = res_out;
                hi_d   = res_hi;
                stat_d = res_stat;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OpMul;
            opnd_q   <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            ovf_q    <= 1'b0;
            out_q    <= '0;
            hi_q     <= '0;
            stat_q   <= '0;
        end else begin
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            ovf_q    <= ovf_d;
            out_q    <= out_d;
            hi_q     <= hi_d;
            stat_q   <= stat_d;
        end
    end

endmodule
